md5_range_counter: RTL and testbench

- Parametrised candidate generator for the brute-force MD5 datapath. Successor to the single-lane 29-bit key counter.
- Walks a loadable inclusive range [start, end] and emits LANES consecutive candidates per accepted beat to LANES hashing cores.
- Supports run, single-step, abort-on-match and valid/ready backpressure.
- Sits between the host/control register block and the core array.

---
 rtl/md5_range_pkg.sv | 23 ++
 rtl/md5_range_counter_lane_mask.sv | 22 ++
 rtl/md5_range_counter.sv | 162 ++++++++++++++++
 tb/tb_md5_range_counter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/md5_range_pkg.sv
// Shared types and helpers for the MD5 candidate range counter.
// Holds the FSM encoding, the lane-count legality check and the per-lane mask rule.
package md5_range_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int MAX_LANES = 64;

    function automatic bit lanes_legal(input int n);
        return (n >= 1) && (n <= MAX_LANES) && ((n & (n - 1)) == 0);
    endfunction

    // Lane i carries base+i, so it is live exactly when i <= end-base.
    function automatic logic lane_on(input int unsigned lane, input logic [63:0] rem);
        return 64'(lane) <= rem;
    endfunction

endpackage

// File: rtl/md5_range_counter_lane_mask.sv
// Combinational remainder -> per-lane mask and last-beat flag.
// Reusable by any scheduler that walks a range LANES candidates at a time.
module md5_lane_mask
    import md5_range_pkg::*;
#(
    parameter int WIDTH = 29,
    parameter int LANES = 4
) (
    input  logic [WIDTH:0]   rem,
    output logic [LANES-1:0] mask,
    output logic             last
);

    always_comb begin
        mask = '0;
        last = rem < (WIDTH + 1)'(LANES);
        for (int i = 0; i < LANES; i++) begin
            mask[i] = lane_on(i, 64'(rem));
        end
    end

endmodule

// File: rtl/md5_range_counter.sv
// Range candidate generator feeding LANES MD5 cores per accepted beat.
// Optional checkpoint on abort: define MD5_RANGE_CKPT_EN to add ckpt_base/ckpt_valid.
module md5_range_counter
    import md5_range_pkg::*;
#(
    parameter int WIDTH = 29,
    parameter int LANES = 4
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] start_in,
    input  logic [WIDTH-1:0] end_in,
    input  logic             enable,
    input  logic             step,
    input  logic             abort,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_base,
    output logic [LANES-1:0] out_mask,
    output logic             running,
    output logic             done,
    output logic             aborted,
    output logic             range_err
`ifdef MD5_RANGE_CKPT_EN
    ,
    output logic [WIDTH-1:0] ckpt_base,
    output logic             ckpt_valid
`endif
);

    if (!lanes_legal(LANES)) begin : g_bad_lanes
        $error("md5_range_counter: LANES must be a power of two in 1..64");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] base_q, base_d;
    logic [WIDTH-1:0] end_q, end_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;
    logic             range_err_q, range_err_d;

    logic [WIDTH:0]   rem;
    logic [LANES-1:0] lane_mask;
    logic             last_beat;
    logic             accept;

    // Extra bit keeps end-base from wrapping; base never passes end while valid.
    assign rem = {1'b0, end_q} - {1'b0, base_q};

    md5_lane_mask #(.WIDTH(WIDTH), .LANES(LANES)) u_lane_mask (
        .rem  (rem),
        .mask (lane_mask),
        .last (last_beat)
    );

    // Handshake: a beat transfers on a cycle where out_valid && out_ready.
    // An unaccepted beat keeps out_base/out_mask stable until taken, aborted,
    // or withdrawn by enable dropping in RUN.
    assign out_valid = (state_q == RUN) || (state_q == STEP);
    assign accept    = out_valid && out_ready;
    assign out_base  = base_q;
    assign out_mask  = out_valid ? lane_mask : '0;
    assign running   = (state_q == RUN);
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign range_err = range_err_q;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        end_d       = end_q;
        done_d      = done_q;
        aborted_d   = aborted_q;
        range_err_d = range_err_q;
        if (load) begin
            base_d    = start_in;
            end_d     = end_in;
            aborted_d = 1'b0;
            if (end_in < start_in) begin
                state_d     = DONE;
                range_err_d = 1'b1;
                done_d      = 1'b1;
            end else begin
                state_d     = IDLE;
                range_err_d = 1'b0;
                done_d      = 1'b0;
            end
        end else if (abort && (state_q != DONE)) begin
            state_d   = DONE;
            done_d    = 1'b1;
            aborted_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable)    state_d = RUN;
                    else if (step) state_d = STEP;
                end
                RUN, STEP: begin
                    if (accept && last_beat) begin
                        // Last beat leaves base alone so a range ending at the top never wraps.
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        if (accept) base_d = base_q + WIDTH'(LANES);
                        if ((state_q == STEP) ? accept : !enable) state_d = IDLE;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q     <= IDLE;
            base_q      <= '0;
            end_q       <= '0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            range_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            end_q       <= end_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
            range_err_q <= range_err_d;
        end
    end

`ifdef MD5_RANGE_CKPT_EN
    logic [WIDTH-1:0] ckpt_base_q, ckpt_base_d;
    logic             ckpt_valid_q, ckpt_valid_d;

    always_comb begin
        ckpt_base_d  = ckpt_base_q;
        ckpt_valid_d = ckpt_valid_q;
        if (load) begin
            ckpt_base_d  = '0;
            ckpt_valid_d = 1'b0;
        end else if (abort && (state_q != DONE)) begin
            ckpt_base_d  = base_q;
            ckpt_valid_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            ckpt_base_q  <= '0;
            ckpt_valid_q <= 1'b0;
        end else begin
            ckpt_base_q  <= ckpt_base_d;
            ckpt_valid_q <= ckpt_valid_d;
        end
    end

    assign ckpt_base  = ckpt_base_q;
    assign ckpt_valid = ckpt_valid_q;
`endif

endmodule

// File: tb/tb_md5_range_counter.sv
// Self-checking bench for md5_range_counter (WIDTH=8, LANES=4).
// Expected beats come from a plain-arithmetic walk of [start, end] in LANES strides.
module tb_md5_range_counter;

    localparam int W = 8;
    localparam int L = 4;

    logic         CLK = 1'b0;
    logic         reset, load, enable, step, abort, out_ready;
    logic [W-1:0] start_in, end_in, out_base;
    logic         out_valid, running, done, aborted, range_err;
    logic [L-1:0] out_mask;
`ifdef MD5_RANGE_CKPT_EN
    logic [W-1:0] ckpt_base;
    logic         ckpt_valid;
`endif

    int errors = 0;
    int checks = 0;

    logic [W-1:0] exp_q[$];
    logic [L-1:0] exp_mask_q[$];

    always #5 CLK = ~CLK;

    md5_range_counter #(.WIDTH(W), .LANES(L)) dut (
        .CLK       (CLK),
        .reset     (reset),
        .load      (load),
        .start_in  (start_in),
        .end_in    (end_in),
        .enable    (enable),
        .step      (step),
        .abort     (abort),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_base  (out_base),
        .out_mask  (out_mask),
        .running   (running),
        .done      (done),
        .aborted   (aborted),
        .range_err (range_err)
`ifdef MD5_RANGE_CKPT_EN
        ,
        .ckpt_base (ckpt_base),
        .ckpt_valid(ckpt_valid)
`endif
    );

    task automatic tick;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        check_val(tag, 32'(obs), 32'(exp));
    endtask

    task automatic do_load(input int s, input int e);
        start_in = W'(s);
        end_in   = W'(e);
        load     = 1'b1;
        tick();
        load     = 1'b0;
    endtask

    // Reference: every candidate in [s, e] appears exactly once, LANES per beat.
    task automatic build_model(input int s, input int e);
        logic [L-1:0] m;
        int n;
        exp_q.delete();
        exp_mask_q.delete();
        for (int b = s; b <= e; b += L) begin
            n = e - b + 1;
            if (n >= L) m = '1;
            else        m = L'((1 << n) - 1);
            exp_q.push_back(W'(b));
            exp_mask_q.push_back(m);
        end
    endtask

    // mode 0: ready always high, 1: ready pattern 1,0,0,1, 2: random ready
    task automatic run_range(input int s, input int e, input int mode);
        logic [3:0]   pat;
        logic         r, held;
        logic [W-1:0] hb;
        logic [L-1:0] hm;
        int           cyc;
        pat  = 4'b1001;
        held = 1'b0;
        hb   = '0;
        hm   = '0;
        do_load(s, e);
        check_bit("load_range_err", range_err, 1'b0);
        check_bit("load_done", done, 1'b0);
        build_model(s, e);
        enable = 1'b1;
        tick();
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 400) begin
            case (mode)
                0:       r = 1'b1;
                1:       r = pat[cyc % 4];
                default: r = ($urandom_range(0, 2) != 0);
            endcase
            out_ready = r;
            check_bit("beat_valid", out_valid, 1'b1);
            if (out_valid) begin
                if (held) begin
                    check_val("stall_base", 32'(out_base), 32'(hb));
                    check_val("stall_mask", 32'(out_mask), 32'(hm));
                end
                if (r) begin
                    check_val("beat_base", 32'(out_base), 32'(exp_q.pop_front()));
                    check_val("beat_mask", 32'(out_mask), 32'(exp_mask_q.pop_front()));
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    hb   = out_base;
                    hm   = out_mask;
                end
            end
            tick();
            cyc++;
        end
        check_bit("range_complete", exp_q.size() == 0, 1'b1);
        check_bit("end_done", done, 1'b1);
        check_bit("end_valid", out_valid, 1'b0);
        check_bit("end_running", running, 1'b0);
        tick();
        check_bit("done_ignores_enable", out_valid, 1'b0);
        enable    = 1'b0;
        out_ready = 1'b0;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, e;
        reset = 1'b1; load = 1'b0; enable = 1'b0; step = 1'b0; abort = 1'b0;
        out_ready = 1'b0; start_in = '0; end_in = '0;
        @(negedge CLK);
        tick();
        check_bit("rst_valid", out_valid, 1'b0);
        check_bit("rst_running", running, 1'b0);
        check_bit("rst_done", done, 1'b0);
        check_bit("rst_aborted", aborted, 1'b0);
        check_bit("rst_range_err", range_err, 1'b0);
        check_val("rst_base", 32'(out_base), 32'd0);
        check_val("rst_mask", 32'(out_mask), 32'd0);
        reset = 1'b0;
        tick();

        run_range(8'h10, 8'h1F, 0);
        run_range(8'h10, 8'h12, 0);
        run_range(8'hFC, 8'hFF, 0);
        run_range(8'h10, 8'h1F, 1);

        // single-step: two beats then nothing
        do_load(0, 7);
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            check_bit("step_valid", out_valid, 1'b1);
            check_bit("step_running", running, 1'b0);
            check_val("step_base", 32'(out_base), 32'(4 * k));
            check_val("step_mask", 32'(out_mask), 32'hF);
            tick();
            check_bit("step_after_valid", out_valid, 1'b0);
            check_bit("step_done", done, k == 1);
        end
        step = 1'b1;
        tick();
        step = 1'b0;
        check_bit("step3_valid", out_valid, 1'b0);
        tick();
        check_bit("step3_valid_b", out_valid, 1'b0);
        out_ready = 1'b0;

        // abort with beat 0x14 pending
        do_load(8'h10, 8'h1F);
        enable = 1'b1;
        tick();
        check_val("abort_first_base", 32'(out_base), 32'h10);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_bit("abort_pending_valid", out_valid, 1'b1);
        check_val("abort_pending_base", 32'(out_base), 32'h14);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_bit("abort_done", done, 1'b1);
        check_bit("abort_aborted", aborted, 1'b1);
        check_bit("abort_valid", out_valid, 1'b0);
        check_bit("abort_running", running, 1'b0);
`ifdef MD5_RANGE_CKPT_EN
        check_bit("ckpt_valid", ckpt_valid, 1'b1);
        check_val("ckpt_base", 32'(ckpt_base), 32'h14);
`endif
        enable = 1'b0;
        do_load(0, 3);
        check_bit("reload_aborted", aborted, 1'b0);
        check_bit("reload_done", done, 1'b0);
`ifdef MD5_RANGE_CKPT_EN
        check_bit("reload_ckpt_valid", ckpt_valid, 1'b0);
`endif

        // inverted range
        do_load(8'h20, 8'h10);
        check_bit("rerr_flag", range_err, 1'b1);
        check_bit("rerr_done", done, 1'b1);
        enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_bit("rerr_no_beat", out_valid, 1'b0);
        end
        enable = 1'b0;

        // reset while a beat is pending
        do_load(8'h40, 8'h7F);
        check_bit("rerr_cleared", range_err, 1'b0);
        enable = 1'b1;
        tick();
        check_bit("midrst_valid_before", out_valid, 1'b1);
        reset = 1'b1;
        tick();
        reset  = 1'b0;
        enable = 1'b0;
        check_bit("midrst_valid", out_valid, 1'b0);
        check_val("midrst_base", 32'(out_base), 32'd0);
        check_bit("midrst_running", running, 1'b0);
        tick();

        for (int it = 0; it < 8; it++) begin
            s = int'($urandom_range(0, 255));
            e = s + int'($urandom_range(0, 30));
            if (e > 255) e = 255;
            run_range(s, e, 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
